// File: rtl/bp_stall_histogram_ctrl.sv
// Windowed stall-reason histogram: classifies each unfrozen cycle into one bin,
// snapshots the bins on a window end or dump request and drains them as {tag,count} records.
module bp_stall_histogram_ctrl #(
  parameter int num_reasons_p  = 21,
  parameter int cnt_width_p    = 32,
  parameter int window_width_p = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      freeze_i,
  input  logic [window_width_p-1:0] window_len_i,
  input  logic                      dump_i,
  input  logic                      commit_v_i,
  input  logic                      stall_v_i,
  input  logic [4:0]                stall_reason_i,
  output logic                      v_o,
  output logic [8+cnt_width_p-1:0]  data_o,
  input  logic                      ready_i,
  output logic                      busy_o,
  output logic                      overrun_o
);

  localparam int bins_lp      = num_reasons_p + 2;
  localparam int instr_bin_lp = num_reasons_p;
  localparam int unk_bin_lp   = num_reasons_p + 1;
  localparam int idx_w_lp     = $clog2(bins_lp);

  localparam logic [4:0]          num_reasons_lp = 5'(num_reasons_p);
  localparam logic [idx_w_lp-1:0] last_idx_lp    = idx_w_lp'(bins_lp - 1);

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e                    state;
  logic [cnt_width_p-1:0]    live      [bins_lp];
  logic [cnt_width_p-1:0]    live_next [bins_lp];
  logic [cnt_width_p-1:0]    shadow    [bins_lp];
  logic [window_width_p-1:0] window_cnt;
  logic [idx_w_lp-1:0]       idx;
  logic [idx_w_lp-1:0]       idx_nxt;
  logic [idx_w_lp-1:0]       sel;
  logic                      window_hit;
  logic                      trigger;

  function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    sel = idx_w_lp'(unk_bin_lp);
    if (commit_v_i)
      sel = idx_w_lp'(instr_bin_lp);
    else if (stall_v_i && (stall_reason_i < num_reasons_lp))
      sel = idx_w_lp'(stall_reason_i);
  end

  always_comb begin
    for (int i = 0; i < bins_lp; i++)
      live_next[i] = (!freeze_i && (sel == idx_w_lp'(i))) ? sat_inc(live[i]) : live[i];
  end

  // Compare one bit wider so window_cnt+1 cannot wrap against a maximal window length.
  assign window_hit = !freeze_i && (window_len_i != '0) &&
                      (({1'b0, window_cnt} + 1'b1) >= {1'b0, window_len_i});
  assign trigger    = dump_i | window_hit;
  assign idx_nxt    = idx + 1'b1;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < bins_lp; i++) live[i] <= '0;
      window_cnt <= '0;
    end else begin
      // A trigger during a drain leaves the bins accumulating toward the next snapshot.
      for (int i = 0; i < bins_lp; i++)
        live[i] <= (trigger && state == IDLE) ? '0 : live_next[i];
      if (trigger)
        window_cnt <= '0;
      else if (!freeze_i)
        window_cnt <= window_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= IDLE;
      idx       <= '0;
      v_o       <= 1'b0;
      busy_o    <= 1'b0;
      data_o    <= '0;
      overrun_o <= 1'b0;
      for (int i = 0; i < bins_lp; i++) shadow[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            for (int i = 0; i < bins_lp; i++) shadow[i] <= live_next[i];
            idx    <= '0;
            state  <= DRAIN;
            v_o    <= 1'b1;
            busy_o <= 1'b1;
            data_o <= {8'd0, live_next[0]};
          end
        end
        DRAIN: begin
          if (trigger) overrun_o <= 1'b1;
          if (ready_i) begin
            if (idx == last_idx_lp) begin
              state  <= IDLE;
              v_o    <= 1'b0;
              busy_o <= 1'b0;
              data_o <= '0;
            end else begin
              idx    <= idx_nxt;
              data_o <= {8'(idx_nxt), shadow[idx_nxt]};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_stall_histogram_ctrl.sv
// Randomized scoreboard bench for bp_stall_histogram_ctrl: a 32-bit and a 4-bit
// counter instance share stimulus and are checked against one arithmetic model.
module tb_bp_stall_histogram_ctrl;

  localparam int NB = 23;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        freeze, dump, commit_v, stall_v, ready;
  logic [15:0] window_len;
  logic [4:0]  stall_reason;

  logic        v_big, busy_big, ovr_big;
  logic [39:0] data_big;
  logic        v_sat, busy_sat, ovr_sat;
  logic [11:0] data_sat;

  int n_checks = 0;
  int n_fail   = 0;

  longint      live_m [NB];
  int          wcnt_m;
  int          remain_m;
  bit          ovr_m;
  logic [39:0] q_big[$];
  logic [11:0] q_sat[$];

  always #5 clk = ~clk;

  bp_stall_histogram_ctrl u_big (
    .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .window_len_i(window_len),
    .dump_i(dump), .commit_v_i(commit_v), .stall_v_i(stall_v), .stall_reason_i(stall_reason),
    .v_o(v_big), .data_o(data_big), .ready_i(ready), .busy_o(busy_big), .overrun_o(ovr_big));

  bp_stall_histogram_ctrl #(.cnt_width_p(4)) u_sat (
    .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .window_len_i(window_len),
    .dump_i(dump), .commit_v_i(commit_v), .stall_v_i(stall_v), .stall_reason_i(stall_reason),
    .v_o(v_sat), .data_o(data_sat), .ready_i(ready), .busy_o(busy_sat), .overrun_o(ovr_sat));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) live_m[i] = 0;
    wcnt_m = 0; remain_m = 0; ovr_m = 0;
    q_big.delete(); q_sat.delete();
  endtask

  // One clock edge of the histogram rules, evaluated on the inputs sampled at that edge.
  task automatic model_step();
    bit draining, trig;
    int sel;
    if (!reset_n) return;
    draining = (remain_m > 0);
    if (!freeze) begin
      if (commit_v) sel = 21;
      else if (stall_v && stall_reason < 21) sel = int'(stall_reason);
      else sel = 22;
      live_m[sel]++;
    end
    trig = dump || (!freeze && window_len != 0 && (wcnt_m + 1) >= int'(window_len));
    if (draining && ready) remain_m--;
    if (trig) begin
      if (!draining) begin
        for (int i = 0; i < NB; i++) begin
          q_big.push_back({8'(i), 32'(live_m[i])});
          q_sat.push_back({8'(i), 4'((live_m[i] > 15) ? 15 : live_m[i])});
          live_m[i] = 0;
        end
        remain_m = NB;
      end else begin
        ovr_m = 1;
      end
      wcnt_m = 0;
    end else if (!freeze) begin
      wcnt_m = (wcnt_m + 1) % 65536;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      chk("busy_big", busy_big, remain_m > 0);
      chk("v_big", v_big, remain_m > 0);
      chk("overrun_big", ovr_big, ovr_m);
      if (v_big) begin
        if (q_big.size() == 0) chk("unexpected_rec_big", 1, 0);
        else begin
          chk("rec_big", data_big, q_big[0]);
          if (ready) void'(q_big.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("busy_sat", busy_sat, remain_m > 0);
      chk("overrun_sat", ovr_sat, ovr_m);
      if (v_sat) begin
        if (q_sat.size() == 0) chk("unexpected_rec_sat", 1, 0);
        else begin
          chk("rec_sat", data_sat, q_sat[0]);
          if (ready) void'(q_sat.pop_front());
        end
      end
    end
  end

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy_big && n < 100) begin cyc(); n++; end
    if (!busy_big) chk({name, "_busy_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    ready = 1'b1;
    while (busy_big && n < 200) begin cyc(); n++; end
    if (busy_big) chk({name, "_idle_timeout"}, 1, 0);
  endtask

  task automatic flush();
    dump = 1'b1; cyc(); dump = 1'b0;
    wait_idle("flush");
  endtask

  initial begin
    int nbusy;
    reset_n = 1'b0; freeze = 0; dump = 0; commit_v = 0; stall_v = 0; ready = 0;
    window_len = '0; stall_reason = '0;
    model_reset();
    #2;
    chk("reset_v", v_big, 0);
    chk("reset_data", data_big, 0);
    chk("reset_busy", busy_big, 0);
    chk("reset_overrun", ovr_big, 0);
    repeat (3) cyc();
    reset_n = 1'b1;

    // Window of 4 committed cycles, then count how long the drain stays busy.
    window_len = 16'd4; commit_v = 1; ready = 1;
    wait_busy("win4");
    window_len = '0;
    nbusy = 0;
    while (busy_big && nbusy < 60) begin nbusy++; cyc(); end
    chk("win4_busy_cycles", nbusy, 23);
    chk("win4_no_overrun", ovr_big, 0);
    commit_v = 0;

    // Stall reason 11 and out-of-range reason 25, then a manual dump.
    flush();
    stall_v = 1; stall_reason = 5'd11;
    repeat (10) cyc();
    stall_reason = 5'd25;
    repeat (3) cyc();
    dump = 1; cyc(); dump = 0; stall_v = 0;
    wait_idle("reason");

    // Backpressure at tag 7 for 5 cycles.
    dump = 1; cyc(); dump = 0; ready = 1;
    begin
      int n = 0;
      while (!(v_big && data_big[39:32] == 8'd7) && n < 50) begin cyc(); n++; end
      chk("tag7_reached", data_big[39:32], 8'd7);
    end
    ready = 0;
    repeat (5) cyc();
    wait_idle("stall_ready");

    // Saturation of the 4-bit instance.
    commit_v = 1;
    repeat (20) cyc();
    dump = 1; cyc(); dump = 0; commit_v = 0;
    wait_idle("sat");

    // Overrun: window of 8 with the consumer stalled.
    flush();
    window_len = 16'd8; commit_v = 1; ready = 0;
    repeat (30) cyc();
    chk("overrun_set", ovr_big, 1);
    window_len = '0;
    wait_idle("ovr_drain");
    commit_v = 1;
    repeat (5) cyc();
    dump = 1; cyc(); dump = 0; commit_v = 0;
    wait_idle("ovr_dump");

    // Freeze for 6 cycles in the middle of a window.
    window_len = 16'd10; commit_v = 1;
    repeat (4) cyc();
    freeze = 1; repeat (6) cyc(); freeze = 0;
    repeat (12) cyc();
    window_len = '0; commit_v = 0;
    wait_idle("freeze");

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      freeze       = ($urandom_range(0, 7) == 0);
      dump         = ($urandom_range(0, 39) == 0);
      commit_v     = ($urandom_range(0, 2) == 0);
      stall_v      = $urandom_range(0, 1);
      stall_reason = 5'($urandom_range(0, 31));
      ready        = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 4))
          0: window_len = 16'd0;
          1: window_len = 16'd3;
          2: window_len = 16'd10;
          3: window_len = 16'd30;
          default: window_len = 16'd60;
        endcase
      end
      cyc();
    end
    freeze = 0; dump = 0; commit_v = 0; stall_v = 0; window_len = '0;
    wait_idle("random");
    chk("queue_big_empty", q_big.size(), 0);
    chk("queue_sat_empty", q_sat.size(), 0);

    // Asynchronous reset in the middle of a drain.
    dump = 1; cyc(); dump = 0; ready = 1;
    repeat (3) cyc();
    chk("pre_reset_busy", busy_big, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_v", v_big, 0);
    chk("async_busy", busy_big, 0);
    chk("async_overrun", ovr_big, 0);
    chk("async_data", data_big, 0);
    chk("async_v_sat", v_sat, 0);
    model_reset();
    cyc();
    reset_n = 1'b1;
    commit_v = 1;
    repeat (7) cyc();
    dump = 1; cyc(); dump = 0; commit_v = 0;
    wait_idle("post_reset");
    chk("final_queue_empty", q_big.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
